// File: rtl/pc_sequencer_if.sv
// Fetch-sequencer bus: decoder controls, LUT lookup pair and PC/status outputs.
// The master side (decoder / LUT / testbench) drives the controls and the LUT
// read data; the slave side (pc_sequencer) drives the PC, the LUT pointer and
// the status flags.
interface pc_sequencer_if #(
    parameter int PC_W  = 10,
    parameter int LUT_W = 5
);
    logic             start;
    logic [1:0]       prog_sel;
    logic             stall;
    logic             branch_en;
    logic             branch_cond;
    logic [3:0]       lut_ptr_in;
    logic [LUT_W-1:0] lut_pointer;
    logic [PC_W-1:0]  abs_address;
    logic             halt;
    logic [PC_W-1:0]  prog_ctr;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [15:0]      instr_count;

    modport master (
        output start, prog_sel, stall, branch_en, branch_cond, lut_ptr_in,
               abs_address, halt,
        input  lut_pointer, prog_ctr, busy, done, timeout, instr_count
    );

    modport slave (
        input  start, prog_sel, stall, branch_en, branch_cond, lut_ptr_in,
               abs_address, halt,
        output lut_pointer, prog_ctr, busy, done, timeout, instr_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter and fetch sequencer for the single-cycle core.
// Launches one of three resident programs, steps the PC each cycle, resolves
// taken branches through the branch-target LUT in the same cycle, and parks in
// DONE on halt or when the RUN watchdog expires.
module pc_sequencer #(
    parameter int PC_W       = 10,
    parameter int LUT_W      = 5,
    parameter int PROG0_BASE = 0,
    parameter int PROG1_BASE = 200,
    parameter int PROG2_BASE = 500,
    parameter int LUT0_BASE  = 0,
    parameter int LUT1_BASE  = 10,
    parameter int LUT2_BASE  = 15,
    parameter int MAX_CYC    = 4095
) (
    input  logic          clk,
    input  logic          rst,
    pc_sequencer_if.slave bus
);

    // Cycle counter only has to reach MAX_CYC: it stops counting on timeout.
    localparam int               CYC_W     = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);
    localparam logic [CYC_W-1:0] CYC_LIMIT = CYC_W'(MAX_CYC);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [1:0]       prog_q, prog_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [15:0]      icnt_q, icnt_d;
    logic             timeout_q, timeout_d;

    logic [1:0]       start_prog;
    logic [PC_W-1:0]  start_pc;
    logic [LUT_W-1:0] lut_base;
    logic [15:0]      icnt_inc;
    logic             branch_taken;

    // Program select 3 is illegal and quietly runs program 1.
    assign start_prog   = (bus.prog_sel == 2'd3) ? 2'd0 : bus.prog_sel;
    assign branch_taken = bus.branch_en && bus.branch_cond;

    // Retired-instruction count sticks at all-ones instead of wrapping.
    assign icnt_inc = (icnt_q == 16'hFFFF) ? icnt_q : icnt_q + 16'd1;

    // Start PC of the program being launched.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
        start_pc = PC_W'(PROG0_BASE);
        case (start_prog)
            2'd1:    start_pc = PC_W'(PROG1_BASE);
            2'd2:    start_pc = PC_W'(PROG2_BASE);
            default: start_pc = PC_W'(PROG0_BASE);
        endcase
    end

    // LUT window owned by the latched program; valid in every state.
    always_comb begin
        lut_base = LUT_W'(LUT0_BASE);
        case (prog_q)
            2'd1:    lut_base = LUT_W'(LUT1_BASE);
            2'd2:    lut_base = LUT_W'(LUT2_BASE);
            default: lut_base = LUT_W'(LUT0_BASE);
        endcase
    end

    // Branch index is program-relative; the sum wraps modulo 2^LUT_W.
    assign bus.lut_pointer = lut_base + LUT_W'(bus.lut_ptr_in);

    // Next-state and next-datapath logic; RUN events are in priority order.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        prog_d    = prog_q;
        cyc_d     = cyc_q;
        icnt_d    = icnt_q;
        timeout_d = timeout_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d   = S_RUN;
                    prog_d    = start_prog;
                    pc_d      = start_pc;
                    cyc_d     = '0;
                    icnt_d    = '0;
                    timeout_d = 1'b0;
                end
            end

            S_RUN: begin
                if (cyc_q == CYC_LIMIT) begin
                    // Watchdog: PC and count freeze where they are.
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                    if (bus.stall) begin
                        // Stalled cycle retires nothing but still costs watchdog time.
                        pc_d = pc_q;
                    end else if (bus.halt) begin
                        // Halt beats a simultaneous branch and counts as retired.
                        state_d = S_DONE;
                        icnt_d  = icnt_inc;
                    end else if (branch_taken) begin
                        // Same-cycle LUT read: target is already on abs_address.
                        pc_d   = bus.abs_address;
                        icnt_d = icnt_inc;
                    end else begin
                        pc_d   = pc_q + PC_W'(1);
                        icnt_d = icnt_inc;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: PC, latched program, watchdog, retire count, timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= '0;
            prog_q    <= '0;
            cyc_q     <= '0;
            icnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            prog_q    <= prog_d;
            cyc_q     <= cyc_d;
            icnt_q    <= icnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.prog_ctr    = pc_q;
    assign bus.busy        = (state_q == S_RUN);
    assign bus.done        = (state_q == S_DONE);
    assign bus.timeout     = timeout_q;
    assign bus.instr_count = icnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
// One DUT with PROG2_BASE=1022 (for the wrap run) and MAX_CYC=20 (watchdog);
// all other runs finish well inside 20 RUN cycles.
module tb_pc_sequencer;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    pc_sequencer_if #(.PC_W(10), .LUT_W(5)) bus ();

    pc_sequencer #(
        .PC_W       (10),
        .LUT_W      (5),
        .PROG0_BASE (0),
        .PROG1_BASE (200),
        .PROG2_BASE (1022),
        .LUT0_BASE  (0),
        .LUT1_BASE  (10),
        .LUT2_BASE  (15),
        .MAX_CYC    (20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.start       = 1'b0;
        bus.prog_sel    = 2'd0;
        bus.stall       = 1'b0;
        bus.branch_en   = 1'b0;
        bus.branch_cond = 1'b0;
        bus.lut_ptr_in  = 4'd0;
        bus.abs_address = 10'd0;
        bus.halt        = 1'b0;
    endtask

    task automatic launch(input logic [1:0] sel);
        bus.prog_sel = sel;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
    endtask

    // Safety net: never let the run hang.
    initial begin
        #100000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int n;
        clear_inputs();
        rst = 1'b1;
        #12;

        // ---- reset state ----
        check("rst_pc",      bus.prog_ctr,    0);
        check("rst_busy",    bus.busy,        0);
        check("rst_done",    bus.done,        0);
        check("rst_timeout", bus.timeout,     0);
        check("rst_icnt",    bus.instr_count, 0);
        bus.lut_ptr_in = 4'd7;
        #1;
        check("rst_lutptr",  bus.lut_pointer, 7);
        bus.lut_ptr_in = 4'd0;
        @(negedge clk);
        rst = 1'b0;

        // ---- sequential run, program 1, halt after 8 steps ----
        launch(2'd0);
        check("seq_busy", bus.busy, 1);
        check("seq_pc0",  bus.prog_ctr, 0);
        check("seq_icnt0", bus.instr_count, 0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("seq_pc", bus.prog_ctr, i);
        end
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        check("seq_done",    bus.done,        1);
        check("seq_busy_lo", bus.busy,        0);
        check("seq_pc_halt", bus.prog_ctr,    8);
        check("seq_icnt",    bus.instr_count, 9);
        check("seq_timeout", bus.timeout,     0);
        tick();
        tick();
        check("seq_pc_hold",   bus.prog_ctr,    8);
        check("seq_icnt_hold", bus.instr_count, 9);
        check("seq_done_hold", bus.done,        1);

        // ---- reset mid-run, program 2 ----
        launch(2'd1);
        check("mid_pc0", bus.prog_ctr, 200);
        repeat (5) tick();
        check("mid_pc5",   bus.prog_ctr,    205);
        check("mid_icnt5", bus.instr_count, 5);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_pc",   bus.prog_ctr,    0);
        check("mid_rst_busy", bus.busy,        0);
        check("mid_rst_done", bus.done,        0);
        check("mid_rst_icnt", bus.instr_count, 0);
        bus.lut_ptr_in = 4'd7;
        #1;
        check("mid_rst_lutptr", bus.lut_pointer, 7);
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();

        // ---- branch resolution, program 2 ----
        launch(2'd1);
        check("br_pc0", bus.prog_ctr, 200);
        bus.lut_ptr_in  = 4'd2;
        bus.branch_en   = 1'b1;
        bus.branch_cond = 1'b0;
        bus.abs_address = 10'd345;
        #1;
        check("br_lutptr", bus.lut_pointer, 12);
        tick();
        check("br_not_taken_pc", bus.prog_ctr,    201);
        check("br_not_taken_ic", bus.instr_count, 1);
        bus.branch_cond = 1'b1;
        tick();
        check("br_taken_pc", bus.prog_ctr,    345);
        check("br_taken_ic", bus.instr_count, 2);
        bus.lut_ptr_in = 4'd15;
        #1;
        check("br_lutptr_max", bus.lut_pointer, 25);

        // ---- stall, then halt beating branch ----
        bus.branch_en   = 1'b0;
        bus.branch_cond = 1'b0;
        bus.stall       = 1'b1;
        tick();
        tick();
        bus.halt = 1'b1;
        tick();
        check("stall_pc",   bus.prog_ctr,    345);
        check("stall_icnt", bus.instr_count, 2);
        check("stall_busy", bus.busy,        1);
        bus.stall       = 1'b0;
        bus.branch_en   = 1'b1;
        bus.branch_cond = 1'b1;
        bus.abs_address = 10'd777;
        tick();
        check("prio_done", bus.done,        1);
        check("prio_pc",   bus.prog_ctr,    345);
        check("prio_icnt", bus.instr_count, 3);
        clear_inputs();
        bus.lut_ptr_in = 4'd2;
        #1;
        check("done_lutptr", bus.lut_pointer, 12);

        // ---- illegal select 3 falls back to program 1 ----
        launch(2'd3);
        check("ill_pc",   bus.prog_ctr,    0);
        check("ill_lut",  bus.lut_pointer, 2);
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        check("ill_done", bus.done, 1);

        // ---- program 3 at 1022 wraps through 0 ----
        launch(2'd2);
        check("wrap_pc0", bus.prog_ctr,    1022);
        check("wrap_lut", bus.lut_pointer, 17);
        tick();
        check("wrap_pc1", bus.prog_ctr, 1023);
        tick();
        check("wrap_pc2", bus.prog_ctr, 0);
        tick();
        check("wrap_pc3", bus.prog_ctr, 1);
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        check("wrap_done", bus.done,        1);
        check("wrap_icnt", bus.instr_count, 4);

        // ---- watchdog, Start ignored in RUN, restart from DONE ----
        bus.lut_ptr_in = 4'd3;
        launch(2'd0);
        check("wd_pc0", bus.prog_ctr, 0);
        repeat (5) tick();
        bus.prog_sel = 2'd2;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        check("wd_start_ignored", bus.prog_ctr,    6);
        check("wd_lut_unlatched", bus.lut_pointer, 3);
        repeat (4) tick();
        check("wd_pc10",   bus.prog_ctr, 10);
        check("wd_busy10", bus.busy,     1);
        n = 0;
        while (!bus.done && n < 40) begin
            tick();
            n++;
        end
        check("wd_reached_done", bus.done, 1);
        check("wd_cycles",       n,        11);
        check("wd_timeout",      bus.timeout,     1);
        check("wd_pc",           bus.prog_ctr,    20);
        check("wd_icnt",         bus.instr_count, 20);
        tick();
        check("wd_timeout_hold", bus.timeout, 1);
        launch(2'd1);
        check("re_busy",    bus.busy,        1);
        check("re_done",    bus.done,        0);
        check("re_timeout", bus.timeout,     0);
        check("re_pc",      bus.prog_ctr,    200);
        check("re_icnt",    bus.instr_count, 0);
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        check("re_halt_done",    bus.done,    1);
        check("re_halt_timeout", bus.timeout, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
